// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone B4 pipelined initiator that copies len_i 32-bit words
// from src_adr_i to dst_adr_i, one read then one write per word, never more than
// one request outstanding. An error response aborts the copy and sets sticky err_o.
// Optional feature macro: WB_COPY_TIMEOUT_EN adds a per-access ack/err timeout of
// TIMEOUT_CYCLES cycles; without it a wait state waits indefinitely.
module wb_copy_master #(
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 start_i,
   input  logic [31:0]          src_adr_i,
   input  logic [31:0]          dst_adr_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [31:0]          wb_dat_o,
   output logic [3:0]           wb_sel_o,
   input  logic                 wb_stall_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i,
   input  logic [31:0]          wb_dat_i
);

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StWrReq,
      StWrWait,
      StDone
   } state_e;

   state_e               r_state;
   logic [31:0]          r_src;
   logic [31:0]          r_dst;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic                 r_cyc;
   logic                 r_stb;
   logic                 r_we;
   logic [31:0]          r_adr;
   logic [31:0]          r_dat;
   logic [3:0]           r_sel;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;

   logic                 w_req;
   logic                 w_wait;
   logic                 w_accept;
   logic                 w_complete;
   logic                 w_tmo_hit;
   logic                 w_abort;
   logic                 w_last;
   logic [31:0]          w_src_nxt;
   logic [31:0]          w_dst_nxt;

   // Decode bus handshake events for the current state
   always_comb begin
      w_req      = (r_state == StRdReq) || (r_state == StWrReq);
      w_wait     = (r_state == StRdWait) || (r_state == StWrWait);
      w_accept   = w_req && !wb_stall_i;
      // An ack landing in the same cycle the request is accepted completes it
      w_complete = (w_accept || w_wait) && wb_ack_i;
      w_abort    = (w_req || w_wait) && (wb_err_i || w_tmo_hit);
      w_last     = (r_cnt == LEN_WIDTH'(1));
      w_src_nxt  = r_src + 32'd4;
      w_dst_nxt  = r_dst + 32'd4;
   end

`ifdef WB_COPY_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TmoW-1:0] r_tmo;

   // Wait-cycle counter, restarted whenever a request is accepted
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_tmo <= '0;
      end else if (w_accept) begin
         r_tmo <= '0;
      end else if (w_wait) begin
         r_tmo <= r_tmo + TmoW'(1);
      end
   end

   assign w_tmo_hit = w_wait && !wb_ack_i && (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   // Copy FSM with all bus and status outputs registered
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= StIdle;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_sel   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (start_i) begin
                     r_err <= 1'b0;
                     if (len_i == '0) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                     end else begin
                        r_src   <= {src_adr_i[31:2], 2'b00};
                        r_dst   <= {dst_adr_i[31:2], 2'b00};
                        r_cnt   <= len_i;
                        r_state <= StRdReq;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= {src_adr_i[31:2], 2'b00};
                        r_sel   <= 4'hF;
                        r_busy  <= 1'b1;
                     end
                  end
               end
               StRdReq, StRdWait: begin
                  if (w_complete) begin
                     r_dat   <= wb_dat_i;
                     r_state <= StWrReq;
                     r_stb   <= 1'b1;
                     r_we    <= 1'b1;
                     r_adr   <= r_dst;
                  end else if (w_accept) begin
                     r_state <= StRdWait;
                     r_stb   <= 1'b0;
                  end
               end
               StWrReq, StWrWait: begin
                  if (w_complete) begin
                     r_src <= w_src_nxt;
                     r_dst <= w_dst_nxt;
                     r_cnt <= r_cnt - LEN_WIDTH'(1);
                     if (w_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= StRdReq;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= w_src_nxt;
                     end
                  end else if (w_accept) begin
                     r_state <= StWrWait;
                     r_stb   <= 1'b0;
                  end
               end
               StDone: begin
                  r_state <= StIdle;
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign busy_o   = r_busy;
   assign done_o   = r_done;
   assign err_o    = r_err;
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign wb_we_o  = r_we;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;
   assign wb_sel_o = r_sel;

endmodule
